// File: rtl/tlp_xcvr_pkg.sv
// Shared types for the TLP transmit path.
// Chunk index, host QW address, chunk size and scheduler states.
package tlp_xcvr_pkg;

  localparam int F2C_PTR_WIDTH = 2;
  localparam int F2C_CHUNK_QWS = 16;

  typedef logic [F2C_PTR_WIDTH-1:0] F2CChunkIndex;
  typedef logic [28:0]              QwAddr;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DHDR,
    S_DATA,
    S_MHDR,
    S_MDATA
  } SchedState;

endpackage

// File: rtl/f2c_dma_sched.sv
// FPGA->CPU DMA scheduler: moves 128-byte chunks from the F2C FIFO
// into the host ring, each followed by a 1-QW write-pointer update.
// Ports:
//   pcieClk_in/pcieRst_in     clock, async active-high reset
//   dmaEnable_in              ring enable (low clears wrPtr)
//   f2cBase_in/mtrBase_in     host QW addresses of ring / metrics
//   rdPtr_in                  CPU consumer chunk index
//   srcLevel_in/srcData_in    source FIFO level and head
//   srcRead_out               source FIFO pop
//   txReq_out/txAck_in        header handshake
//   txQwAddr_out/txDwCount_out header fields
//   txData_out/txDataValid_out/txDataReady_in  payload handshake
//   wrPtr_out/busy_out        status
module f2c_dma_sched
  import tlp_xcvr_pkg::*;
#(
  parameter int CHUNK_QWS = F2C_CHUNK_QWS,
  parameter int PTR_WIDTH = F2C_PTR_WIDTH,
  parameter int LVL_WIDTH = 10
) (
  input  logic                 pcieClk_in,
  input  logic                 pcieRst_in,
  input  logic                 dmaEnable_in,
  input  logic [28:0]          f2cBase_in,
  input  logic [28:0]          mtrBase_in,
  input  logic [PTR_WIDTH-1:0] rdPtr_in,
  input  logic [LVL_WIDTH-1:0] srcLevel_in,
  input  logic [63:0]          srcData_in,
  output logic                 srcRead_out,
  output logic                 txReq_out,
  input  logic                 txAck_in,
  output logic [28:0]          txQwAddr_out,
  output logic [9:0]           txDwCount_out,
  output logic [63:0]          txData_out,
  output logic                 txDataValid_out,
  input  logic                 txDataReady_in,
  output logic [PTR_WIDTH-1:0] wrPtr_out,
  output logic                 busy_out
);

  localparam int BEAT_W = $clog2(CHUNK_QWS);

  SchedState            state;
  SchedState            state_nxt;
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] ptr_inc;
  logic [BEAT_W-1:0]    beat_cnt;
  logic                 full;
  logic                 have_chunk;
  logic                 beat_done;
  logic                 last_beat;
  QwAddr                chunk_off;

  assign ptr_inc    = wr_ptr + PTR_WIDTH'(1);
  // One slot is always left unused so full and empty differ.
  assign full       = (ptr_inc == rdPtr_in);
  assign have_chunk = (srcLevel_in >= LVL_WIDTH'(CHUNK_QWS));
  assign beat_done  = (state == S_DATA) && txDataReady_in;
  assign last_beat  = (beat_cnt == BEAT_W'(CHUNK_QWS - 1));
  assign chunk_off  = QwAddr'(wr_ptr) * QwAddr'(CHUNK_QWS);

  always_ff @(posedge pcieClk_in or posedge pcieRst_in) begin
    if (pcieRst_in)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (dmaEnable_in && !full && have_chunk)
          state_nxt = S_DHDR;
      S_DHDR:
        if (txAck_in)
          state_nxt = S_DATA;
      S_DATA:
        if (beat_done && last_beat)
          state_nxt = S_MHDR;
      S_MHDR:
        if (txAck_in)
          state_nxt = S_MDATA;
      S_MDATA:
        if (txDataReady_in)
          state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  // Disable only clears the ring between chunks, never mid-TLP.
  always_ff @(posedge pcieClk_in or posedge pcieRst_in) begin
    if (pcieRst_in) begin
      wr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      if (state == S_IDLE && !dmaEnable_in)
        wr_ptr <= '0;
      else if (beat_done && last_beat)
        wr_ptr <= ptr_inc;
      if (state == S_DHDR)
        beat_cnt <= '0;
      else if (beat_done)
        beat_cnt <= beat_cnt + BEAT_W'(1);
    end
  end

  always_comb begin
    txReq_out       = 1'b0;
    txQwAddr_out    = '0;
    txDwCount_out   = '0;
    txDataValid_out = 1'b0;
    txData_out      = '0;
    srcRead_out     = 1'b0;
    unique case (state)
      S_DHDR: begin
        txReq_out     = 1'b1;
        txQwAddr_out  = f2cBase_in + chunk_off;
        txDwCount_out = 10'(2 * CHUNK_QWS);
      end
      S_DATA: begin
        txDataValid_out = 1'b1;
        txData_out      = srcData_in;
        srcRead_out     = txDataReady_in;
      end
      S_MHDR: begin
        txReq_out     = 1'b1;
        txQwAddr_out  = mtrBase_in;
        txDwCount_out = 10'd2;
      end
      S_MDATA: begin
        txDataValid_out = 1'b1;
        txData_out      = 64'(wr_ptr);
      end
      default: ;
    endcase
  end

  assign wrPtr_out = wr_ptr;
  assign busy_out  = (state != S_IDLE);

endmodule

// File: tb/tb_f2c_dma_sched.sv
// Bench for f2c_dma_sched: source FIFO and transmitter models
// with a transaction-level ring model checking every TLP.
module tb_f2c_dma_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [28:0] f2c_base = '0;
  logic [28:0] mtr_base = '0;
  logic [1:0]  rd_ptr = '0;
  logic [9:0]  src_level = '0;
  logic [63:0] src_data = '0;
  logic        src_read;
  logic        tx_req;
  logic        tx_ack = 1'b0;
  logic [28:0] tx_addr;
  logic [9:0]  tx_dw;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_rdy = 1'b0;
  logic [1:0]  wr_ptr;
  logic        busy;

  always #5 clk = ~clk;

  f2c_dma_sched dut (
    .pcieClk_in      (clk),
    .pcieRst_in      (rst),
    .dmaEnable_in    (en),
    .f2cBase_in      (f2c_base),
    .mtrBase_in      (mtr_base),
    .rdPtr_in        (rd_ptr),
    .srcLevel_in     (src_level),
    .srcData_in      (src_data),
    .srcRead_out     (src_read),
    .txReq_out       (tx_req),
    .txAck_in        (tx_ack),
    .txQwAddr_out    (tx_addr),
    .txDwCount_out   (tx_dw),
    .txData_out      (tx_data),
    .txDataValid_out (tx_valid),
    .txDataReady_in  (tx_rdy),
    .wrPtr_out       (wr_ptr),
    .busy_out        (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] fifo_q[$];
  logic [63:0] exp_q[$];
  int m_wr = 0;
  int m_phase = 0;
  int m_beats = 0;
  int n_chunks = 0;
  int n_mtr = 0;
  int n_hdr = 0;
  int n_reads = 0;
  bit bp = 0;
  bit follow = 0;
  logic        prev_req = 0;
  logic        prev_ack = 0;
  logic [28:0] prev_addr = '0;
  logic [9:0]  prev_dw = '0;
  logic [28:0] last_daddr = '0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push_words(input int n);
    logic [63:0] w;
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_req"}, tx_req, 0);
    check({pfx, "_vld"}, tx_valid, 0);
    check({pfx, "_srd"}, src_read, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_addr"}, tx_addr, 0);
    check({pfx, "_dw"}, tx_dw, 0);
    check({pfx, "_data"}, tx_data, 0);
    check({pfx, "_wrptr"}, wr_ptr, 0);
  endtask

  task automatic monitor();
    logic        beat;
    logic        idle_now;
    logic [63:0] want;
    longint      a;
    beat     = tx_valid && tx_rdy;
    idle_now = (m_phase == 0) && !tx_req;
    check("wrptr", wr_ptr, m_wr);
    check("busy", busy, (m_phase != 0) || tx_req);
    check("srd", src_read, beat && (m_phase == 1));
    if (m_phase == 1 || m_phase == 3)
      check("req_in_data", tx_req, 0);
    if (m_phase == 0 || m_phase == 2)
      check("vld_in_hdr", tx_valid, 0);
    if (tx_req && prev_req && !prev_ack) begin
      check("hdr_addr_hold", tx_addr, prev_addr);
      check("hdr_dw_hold", tx_dw, prev_dw);
    end
    prev_req  = tx_req;
    prev_ack  = tx_ack;
    prev_addr = tx_addr;
    prev_dw   = tx_dw;
    if (tx_req && tx_ack) begin
      n_hdr++;
      if (m_phase == 0) begin
        a = longint'(f2c_base) + longint'(m_wr * 16);
        check("dhdr_addr", tx_addr, 29'(a));
        check("dhdr_dw", tx_dw, 32);
        last_daddr = tx_addr;
        m_phase = 1;
        m_beats = 0;
      end else if (m_phase == 2) begin
        check("mhdr_addr", tx_addr, mtr_base);
        check("mhdr_dw", tx_dw, 2);
        m_phase = 3;
      end else begin
        check("hdr_phase", m_phase, 0);
      end
    end
    if (beat) begin
      if (m_phase == 1) begin
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hdead;
        check("data", tx_data, want);
        m_beats++;
        if (m_beats == 16) begin
          m_wr = (m_wr + 1) % 4;
          m_phase = 2;
          n_chunks++;
        end
      end else if (m_phase == 3) begin
        check("mtr_data", tx_data, m_wr);
        m_phase = 0;
        n_mtr++;
      end else begin
        check("beat_phase", m_phase, 1);
      end
    end
    if (src_read) begin
      n_reads++;
      if (fifo_q.size() != 0)
        void'(fifo_q.pop_front());
    end
    if (idle_now && !en)
      m_wr = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    tx_ack = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    tx_rdy = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (follow)
      rd_ptr = 2'(m_wr);
    src_data  = (fifo_q.size() != 0) ? fifo_q[0] : 64'h0;
    src_level = 10'(fifo_q.size());
    #1;
    if (!rst)
      monitor();
  endtask

  initial begin
    int t;
    int h0;
    int c0;
    int r0;

    repeat (3) @(negedge clk);
    #1;
    check_quiet("rst");
    @(negedge clk);
    rst = 1'b0;

    // three chunks fill the ring, the fourth is blocked
    f2c_base = 29'h0;
    mtr_base = 29'h40;
    rd_ptr   = 2'd0;
    push_words(64);
    en = 1'b1;
    for (t = 0; t < 200 && n_mtr < 3; ) begin
      cycle();
      t++;
    end
    check("fill_done", n_mtr, 3);
    check("fill_cycles", t, 60);
    repeat (40) cycle();
    check("full_chunks", n_chunks, 3);
    check("full_busy", busy, 0);
    check("full_req", tx_req, 0);
    check("full_wrptr", wr_ptr, 3);
    check("full_addr", last_daddr, 29'h20);

    // consumer frees one slot: one more chunk with wrap
    rd_ptr = 2'd1;
    for (t = 0; t < 100 && n_mtr < 4; t++) cycle();
    check("wrap_done", n_mtr, 4);
    repeat (30) cycle();
    check("wrap_chunks", n_chunks, 4);
    check("wrap_addr", last_daddr, 29'h30);
    check("wrap_wrptr", wr_ptr, 0);
    check("wrap_busy", busy, 0);

    // level threshold
    rd_ptr = 2'd0;
    push_words(15);
    h0 = n_hdr;
    repeat (20) cycle();
    check("lvl15_hdr", n_hdr, h0);
    check("lvl15_req", tx_req, 0);
    push_words(1);
    cycle();
    check("lvl16_eval", tx_req, 0);
    cycle();
    check("lvl16_req", tx_req, 1);
    for (t = 0; t < 100 && n_mtr < 5; t++) cycle();
    check("lvl16_done", n_mtr, 5);

    // random backpressure, consumer keeps up
    bp = 1;
    follow = 1;
    push_words(128);
    c0 = n_chunks;
    r0 = n_reads;
    for (t = 0; t < 3000 && !(n_chunks == c0 + 8 && m_phase == 0); t++)
      cycle();
    check("bp_chunks", n_chunks, c0 + 8);
    check("bp_reads", n_reads - r0, 16 * 8);
    bp = 0;

    // disable mid-chunk
    push_words(16);
    c0 = n_mtr;
    for (t = 0; t < 100 && !(m_phase == 1 && m_beats == 5); t++) cycle();
    check("dis_reach", m_beats, 5);
    en = 1'b0;
    for (t = 0; t < 100 && n_mtr < c0 + 1; t++) cycle();
    check("dis_finish", n_mtr, c0 + 1);
    check("dis_beats", m_beats, 16);
    push_words(16);
    h0 = n_hdr;
    repeat (30) cycle();
    check("dis_hdr", n_hdr, h0);
    check("dis_wrptr", wr_ptr, 0);
    check("dis_busy", busy, 0);

    // reset mid-TLP
    en = 1'b1;
    push_words(16);
    for (t = 0; t < 100 && !(m_phase == 1 && m_beats == 8); t++) cycle();
    check("rst_reach", m_beats, 8);
    rst = 1'b1;
    #1;
    check_quiet("arst");
    m_phase  = 0;
    m_wr     = 0;
    prev_req = 0;
    f2c_base = 29'h0abc_de0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c0 = n_mtr;
    for (t = 0; t < 100 && n_mtr < c0 + 1; t++) cycle();
    check("rst_done", n_mtr, c0 + 1);
    check("rst_base", last_daddr, 29'h0abc_de0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
